wb_rsa_initiator: RTL and testbench
===================================

WB_RSA_INITIATOR -- requirements
Module: wb_rsa_initiator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand/result width and the Wishbone data width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_4000, meaning the byte address of the RSA responder register window.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 256, meaning the maximum wait in cycles for wb_ack_i per bus transfer.
REQ-004 SHALL have parameter MAX_POLLS, default 4096, meaning the maximum number of status reads per job.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 job_valid  input  1  a job is offered.
REQ-009 job_ready  output  1  the block accepts a job this cycle.
REQ-010 job_msg / job_exp / job_mod  input  WIDTH each  message, exponent and modulus.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer takes the result.
REQ-013 res_data  output  WIDTH  modular exponentiation result.
REQ-014 res_err  output  1  job aborted (ack timeout or poll limit).
REQ-015 wb_adr_o  output  32  byte address.
REQ-016 wb_dat_o  output  WIDTH  write data.
REQ-017 wb_dat_i  input  WIDTH  read data.
REQ-018 wb_we_o  output  1  write enable.
REQ-019 wb_sel_o  output  4  byte select; always 4'hF.
REQ-020 wb_cyc_o / wb_stb_o  output  1 each  cycle and strobe.
REQ-021 wb_ack_i  input  1  responder acknowledge.

Function
REQ-022 Register map (offsets from BASE_ADDR): 0x00 MSG W, 0x04 EXP W, 0x08 MOD W, 0x0C CTRL W (bit0=start), 0x10 STAT R (bit0=done), 0x14 RESULT R.
REQ-023 FSM states and order: IDLE, WR_MSG, WR_EXP, WR_MOD, WR_START, RD_STAT, RD_RES, RESP; any bus state may branch to ERR.
REQ-024 In IDLE, job_ready=1; on job_valid&&job_ready, operands SHALL be latched and the FSM SHALL go to WR_MSG on the next cycle.
REQ-025 Each bus state SHALL assert cyc/stb with stable adr/dat/we until the cycle in which wb_ack_i=1 is sampled, then deassert cyc/stb for exactly one cycle before the next transfer.
REQ-026 WR_START SHALL write 32'h1.
REQ-027 In RD_STAT, if wb_dat_i[0]=0 at ack, the block SHALL re-issue the read after the one-cycle gap; if wb_dat_i[0]=1, it SHALL go to RD_RES.
REQ-028 In RD_RES, wb_dat_i SHALL be captured into res_data at ack, followed by RESP.
REQ-029 In RESP, res_valid=1 with res_data/res_err held stable until res_ready=1, then the FSM SHALL return to IDLE; minimum one cycle in IDLE.
REQ-030 A per-transfer counter SHALL clear at each transfer start; if it reaches ACK_TIMEOUT without ack, cyc/stb SHALL drop and the FSM SHALL go to ERR.
REQ-031 A poll counter SHALL clear on job accept; the MAX_POLLS-th STAT read completing without done SHALL go to ERR.
REQ-032 ERR SHALL present res_valid=1, res_err=1, res_data=0 under the same hold rule, then return to IDLE.
REQ-033 An ack arriving outside an active stb SHALL be ignored.
REQ-034 job_ready SHALL be 0 in every state except IDLE; a job_valid presented outside IDLE SHALL have no effect.
REQ-035 Job latency (zero-wait ack, done on the first poll) SHALL be 1 + 6 transfers x 2 cycles = 13 cycles from accept to res_valid.

Reset
REQ-036 On rst: state=IDLE, cyc/stb/we=0, adr=0, dat_o=0, res_valid=0, res_err=0, res_data=0, all counters=0; job_ready=1 after release.
REQ-037 A reset during an active transfer SHALL drop cyc/stb immediately (asynchronously) and abandon the job; no result SHALL be produced.

Structure
REQ-038 Register offsets, CTRL/STAT bit positions and FSM state encoding SHALL live in a shared package (rsa_pkg), reused by wb_rsa.
REQ-039 A sub-module wb_xfer (single-transfer engine with ack timeout) is natural; the FSM SHALL sequence it.

Verification
REQ-040 msg=4, exp=13, mod=497 with zero-wait ack and done on the first poll -> res_data=445, res_err=0, res_valid at cycle 13.
REQ-041 ack delayed by 5 cycles per transfer -> adr/dat/we stable throughout each wait; result still 445.
REQ-042 STAT returns done on the 10th read -> exactly 10 STAT reads, then one RESULT read.
REQ-043 no ack on WR_EXP for 256 cycles -> cyc drops, res_err=1, res_data=0, no CTRL write issued.
REQ-044 res_ready held 0 for 20 cycles -> res_valid and res_data held stable and job_ready=0 until res_ready=1.
REQ-045 rst asserted mid-RD_STAT -> cyc/stb=0 in the same cycle, no res_valid; a new job afterwards completes correctly.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: register map, control/status bit positions and FSM encoding shared by the RSA initiator and responder.
package rsa_pkg;
  localparam logic [31:0] OFF_MSG    = 32'h00;
  localparam logic [31:0] OFF_EXP    = 32'h04;
  localparam logic [31:0] OFF_MOD    = 32'h08;
  localparam logic [31:0] OFF_CTRL   = 32'h0C;
  localparam logic [31:0] OFF_STAT   = 32'h10;
  localparam logic [31:0] OFF_RESULT = 32'h14;
  localparam int CTRL_START_BIT = 0;
  localparam int STAT_DONE_BIT  = 0;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_MSG   = 4'd1;
  localparam logic [3:0] S_WR_EXP   = 4'd2;
  localparam logic [3:0] S_WR_MOD   = 4'd3;
  localparam logic [3:0] S_WR_START = 4'd4;
  localparam logic [3:0] S_RD_STAT  = 4'd5;
  localparam logic [3:0] S_RD_RES   = 4'd6;
  localparam logic [3:0] S_RESP     = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;
  function automatic logic [31:0] state_off(input logic [3:0] s);
    return s == S_WR_MSG   ? OFF_MSG  :
           s == S_WR_EXP   ? OFF_EXP  :
           s == S_WR_MOD   ? OFF_MOD  :
           s == S_WR_START ? OFF_CTRL :
           s == S_RD_STAT  ? OFF_STAT : OFF_RESULT;
  endfunction
endpackage

// File: rtl/wb_rsa_initiator_if.sv
// wb_rsa_initiator_if: Wishbone classic bus between the RSA initiator (master) and responder (slave).
interface wb_rsa_initiator_if #(parameter int WIDTH = 32);
  logic [31:0]      adr_o;
  logic [WIDTH-1:0] dat_o;
  logic [WIDTH-1:0] dat_i;
  logic             we_o;
  logic [3:0]       sel_o;
  logic             cyc_o;
  logic             stb_o;
  logic             ack_i;
  modport master(output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o, input dat_i, ack_i);
  modport slave(input adr_o, dat_o, we_o, sel_o, cyc_o, stb_o, output dat_i, ack_i);
endinterface

// File: rtl/wb_xfer.sv
// wb_xfer: one Wishbone transfer at a time; adr/dat/we frozen at start, abandoned after ACK_TIMEOUT unacked cycles.
module wb_xfer #(
  parameter int WIDTH       = 32,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             we_i,
  input  logic [31:0]      adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             tout_o,
  wb_rsa_initiator_if.master wb
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic             busy_q;
  logic             we_q;
  logic [31:0]      adr_q;
  logic [WIDTH-1:0] dat_q;
  logic [CW-1:0]    cnt_q;
  assign busy_o    = busy_q;
  assign done_o    = busy_q && wb.ack_i;
  assign tout_o    = busy_q && !wb.ack_i && cnt_q == CW'(ACK_TIMEOUT - 1);
  assign wb.cyc_o  = busy_q;
  assign wb.stb_o  = busy_q;
  assign wb.adr_o  = adr_q;
  assign wb.dat_o  = dat_q;
  assign wb.we_o   = we_q;
  assign wb.sel_o  = 4'hF;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      cnt_q  <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      we_q   <= we_i;
      adr_q  <= adr_i;
      dat_q  <= dat_i;
      cnt_q  <= '0;
    end else if (done_o || tout_o) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q)
      cnt_q <= cnt_q + CW'(1);
endmodule

// File: rtl/wb_rsa_initiator.sv
// wb_rsa_initiator: runs one modular-exponentiation job on a Wishbone RSA responder:
// write operands, start, poll status, read result, then hand the result (or an error) downstream.
module wb_rsa_initiator
  import rsa_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
  parameter int          ACK_TIMEOUT = 256,
  parameter int          MAX_POLLS   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [WIDTH-1:0] job_msg,
  input  logic [WIDTH-1:0] job_exp,
  input  logic [WIDTH-1:0] job_mod,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  wb_rsa_initiator_if.master wb
);
  localparam int PW = $clog2(MAX_POLLS + 1);
  logic [3:0]       state_q, state_d;
  logic [WIDTH-1:0] msg_q, msg_d, exp_q, exp_d, mod_q, mod_d, res_q, res_d;
  logic [PW-1:0]    poll_q, poll_d;
  logic             bus, busy, done, tout, stat_done, poll_fail;
  logic [WIDTH-1:0] wdat;
  assign bus       = state_q >= S_WR_MSG && state_q <= S_RD_RES;
  assign job_ready = state_q == S_IDLE;
  assign res_valid = state_q == S_RESP || state_q == S_ERR;
  assign res_err   = state_q == S_ERR;
  assign res_data  = res_q;
  assign stat_done = wb.dat_i[STAT_DONE_BIT];
  assign poll_fail = state_q == S_RD_STAT && done && !stat_done && poll_q == PW'(MAX_POLLS - 1);
  assign wdat = state_q == S_WR_MSG   ? msg_q :
                state_q == S_WR_EXP   ? exp_q :
                state_q == S_WR_MOD   ? mod_q :
                state_q == S_WR_START ? WIDTH'(1 << CTRL_START_BIT) : '0;
  // The engine is idle for exactly one cycle after each ack, which yields the mandatory bus gap.
  wb_xfer #(.WIDTH(WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .clk(clk), .rst(rst),
    .start_i(bus && !busy), .we_i(state_q <= S_WR_START),
    .adr_i(BASE_ADDR + state_off(state_q)), .dat_i(wdat),
    .busy_o(busy), .done_o(done), .tout_o(tout),
    .wb(wb)
  );
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    res_d   = res_q;
    poll_d  = poll_q;
    if (state_q == S_IDLE && job_valid) begin
      {msg_d, exp_d, mod_d} = {job_msg, job_exp, job_mod};
      poll_d  = '0;
      state_d = S_WR_MSG;
    end else if (tout || poll_fail) begin
      res_d   = '0;
      state_d = S_ERR;
    end else if (done) begin
      poll_d  = state_q == S_RD_STAT ? poll_q + PW'(1) : poll_q;
      res_d   = state_q == S_RD_RES ? wb.dat_i : res_q;
      state_d = state_q == S_RD_STAT ? (stat_done ? S_RD_RES : S_RD_STAT) :
                state_q == S_RD_RES  ? S_RESP : state_q + 4'd1;
    end else if (res_valid && res_ready)
      state_d = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      msg_q   <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      res_q   <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      res_q   <= res_d;
      poll_q  <= poll_d;
    end
endmodule

// File: tb/tb_wb_rsa_initiator.sv
// tb_wb_rsa_initiator: behavioural RSA responder plus scoreboard of expected results per job.
module tb_wb_rsa_initiator;
  typedef struct packed {logic err; logic [31:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0, job_ready, res_valid, res_ready = 1'b1, res_err;
  logic [31:0] job_msg = '0, job_exp = '0, job_mod = '0, res_data;
  int checks = 0, errors = 0;
  exp_t sbq[$];
  int ack_delay = 0, done_at = 1;
  logic [31:0] noack_adr = 32'hFFFF_FFFF;
  logic spur_ack = 1'b0;
  logic [31:0] r_msg = '0, r_exp = '0, r_mod = '0, r_res = '0, off;
  int stat_since = 0, stat_total = 0, res_total = 0, ctrl_total = 0, proto_err = 0;
  int wcnt = 0, stab_err = 0, gap_err = 0;
  logic p_wait = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;

  wb_rsa_initiator_if #(.WIDTH(32)) wb();
  wb_rsa_initiator dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_msg(job_msg), .job_exp(job_exp), .job_mod(job_mod),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .wb(wb)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    logic [63:0] r, x;
    r = 64'd1 % {32'd0, m};
    x = {32'd0, b} % {32'd0, m};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % {32'd0, m};
      x = (x * x) % {32'd0, m};
    end
    return r[31:0];
  endfunction

  assign off = wb.adr_o - 32'h0000_4000;
  assign wb.ack_i = (wb.cyc_o && wb.stb_o && wb.adr_o != noack_adr && wcnt == ack_delay) || spur_ack;
  assign wb.dat_i = wb.adr_o == 32'h0000_4010 ? {31'd0, stat_since + 1 >= done_at} :
                    wb.adr_o == 32'h0000_4014 ? r_res : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    wcnt <= (wb.cyc_o && wb.stb_o && !wb.ack_i) ? wcnt + 1 : 0;
    if (wb.cyc_o && wb.stb_o && wb.ack_i) begin
      proto_err <= proto_err + int'(wb.sel_o !== 4'hF || off > 32'h14 || off[1:0] != 2'b00 ||
                   (off < 32'h10) != wb.we_o || (off == 32'h0C && wb.dat_o !== 32'h1));
      if (off == 32'h00) r_msg <= wb.dat_o;
      if (off == 32'h04) r_exp <= wb.dat_o;
      if (off == 32'h08) r_mod <= wb.dat_o;
      if (off == 32'h0C) begin
        ctrl_total <= ctrl_total + 1;
        stat_since <= 0;
        r_res <= modexp(r_msg, r_exp, r_mod);
      end
      if (off == 32'h10) begin
        stat_total <= stat_total + 1;
        stat_since <= stat_since + 1;
      end
      if (off == 32'h14) res_total <= res_total + 1;
    end
    if (p_wait && wb.stb_o && {wb.adr_o, wb.dat_o, wb.we_o} !== {p_adr, p_dat, p_we}) stab_err <= stab_err + 1;
    if (p_ack && wb.cyc_o) gap_err <= gap_err + 1;
    p_wait <= wb.stb_o && !wb.ack_i;
    p_ack  <= wb.stb_o && wb.ack_i;
    p_adr  <= wb.adr_o;
    p_dat  <= wb.dat_o;
    p_we   <= wb.we_o;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic run_job(input logic [31:0] m, input logic [31:0] e, input logic [31:0] d, input exp_t x, output int lat);
    int n = 0;
    while (!job_ready && n < 50) begin @(posedge clk); #1; n++; end
    {job_msg, job_exp, job_mod} = {m, e, d};
    job_valid = 1'b1;
    sbq.push_back(x);
    @(posedge clk); #1;
    job_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20000) begin @(posedge clk); #1; lat++; end
    if (!res_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wb.cyc_o !== 1'b0 || wb.stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b want 00", wb.cyc_o, wb.stb_o); end
    checks++; if (wb.we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb.we_o); end
    checks++; if (wb.adr_o !== 32'd0) begin errors++; $display("FAIL reset_adr: got %h want 0", wb.adr_o); end
    checks++; if (wb.dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h want 0", wb.dat_o); end
    checks++; if (res_valid !== 1'b0 || res_err !== 1'b0) begin errors++; $display("FAIL reset_res_flags: got v=%b e=%b want 0 0", res_valid, res_err); end
    checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
    checks++; if (wb.sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h want f", wb.sel_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
  endtask

  task automatic test_basic();
    int lat, s0 = stat_total, r0 = res_total, p0 = proto_err, g0 = gap_err;
    exp_t x;
    run_job(32'd4, 32'd13, 32'd497, '{1'b0, 32'd445}, lat);
    x = sbq.pop_front();
    checks++; if (lat !== 13) begin errors++; $display("FAIL basic_latency: got %0d want 13", lat); end
    checks++; if (res_data !== x.data || res_err !== x.err) begin errors++; $display("FAIL basic_result: got %0d err=%b want %0d err=%b", res_data, res_err, x.data, x.err); end
    checks++; if (stat_total - s0 !== 1 || res_total - r0 !== 1) begin errors++; $display("FAIL basic_reads: got stat=%0d res=%0d want 1 1", stat_total - s0, res_total - r0); end
    checks++; if (proto_err - p0 !== 0 || gap_err - g0 !== 0) begin errors++; $display("FAIL basic_protocol: got proto=%0d gap=%0d want 0 0", proto_err - p0, gap_err - g0); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin errors++; $display("FAIL basic_return_idle: got v=%b rdy=%b want 0 1", res_valid, job_ready); end
  endtask

  task automatic test_ack_delay();
    int lat, st0 = stab_err, g0 = gap_err;
    exp_t x;
    ack_delay = 5;
    run_job(32'd4, 32'd13, 32'd497, '{1'b0, 32'd445}, lat);
    x = sbq.pop_front();
    ack_delay = 0;
    checks++; if (lat !== 43) begin errors++; $display("FAIL delay_latency: got %0d want 43", lat); end
    checks++; if (res_data !== x.data || res_err !== x.err) begin errors++; $display("FAIL delay_result: got %0d err=%b want %0d err=%b", res_data, res_err, x.data, x.err); end
    checks++; if (stab_err - st0 !== 0 || gap_err - g0 !== 0) begin errors++; $display("FAIL delay_stability: got unstable=%0d gap=%0d want 0 0", stab_err - st0, gap_err - g0); end
    @(posedge clk); #1;
  endtask

  task automatic test_poll();
    int lat, s0 = stat_total, r0 = res_total;
    exp_t x;
    done_at = 10;
    run_job(32'd7, 32'd11, 32'd1009, '{1'b0, modexp(32'd7, 32'd11, 32'd1009)}, lat);
    x = sbq.pop_front();
    done_at = 1;
    checks++; if (stat_total - s0 !== 10 || res_total - r0 !== 1) begin errors++; $display("FAIL poll_counts: got stat=%0d res=%0d want 10 1", stat_total - s0, res_total - r0); end
    checks++; if (res_data !== x.data || res_err !== x.err) begin errors++; $display("FAIL poll_result: got %0d err=%b want %0d err=%b", res_data, res_err, x.data, x.err); end
    checks++; if (lat !== 31) begin errors++; $display("FAIL poll_latency: got %0d want 31", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_ack_timeout();
    int lat, c0 = ctrl_total;
    exp_t x;
    noack_adr = 32'h0000_4004;
    run_job(32'd5, 32'd3, 32'd7, '{1'b1, 32'd0}, lat);
    x = sbq.pop_front();
    checks++; if (lat !== 260) begin errors++; $display("FAIL timeout_latency: got %0d want 260", lat); end
    checks++; if (res_err !== x.err || res_data !== x.data) begin errors++; $display("FAIL timeout_result: got %0d err=%b want %0d err=%b", res_data, res_err, x.data, x.err); end
    checks++; if (wb.cyc_o !== 1'b0 || wb.stb_o !== 1'b0) begin errors++; $display("FAIL timeout_cyc_drop: got %b%b want 00", wb.cyc_o, wb.stb_o); end
    @(posedge clk); #1;
    noack_adr = 32'hFFFF_FFFF;
    checks++; if (ctrl_total - c0 !== 0) begin errors++; $display("FAIL timeout_no_ctrl: got %0d ctrl writes want 0", ctrl_total - c0); end
  endtask

  task automatic test_backpressure();
    int lat, bad = 0, c0 = ctrl_total;
    exp_t x;
    res_ready = 1'b0;
    run_job(32'd4, 32'd13, 32'd497, '{1'b0, 32'd445}, lat);
    x = sbq.pop_front();
    checks++; if (res_data !== x.data || res_err !== x.err) begin errors++; $display("FAIL bp_result: got %0d err=%b want %0d err=%b", res_data, res_err, x.data, x.err); end
    {job_msg, job_exp, job_mod} = {32'd3, 32'd3, 32'd5};
    job_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bad += int'(res_valid !== 1'b1 || res_data !== x.data || job_ready !== 1'b0 || wb.cyc_o !== 1'b0);
    end
    job_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0 1", res_valid, job_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ctrl_total - c0 !== 1 || wb.cyc_o !== 1'b0) begin errors++; $display("FAIL bp_ignored_job: got ctrl=%0d cyc=%b want 1 0", ctrl_total - c0, wb.cyc_o); end
  endtask

  task automatic test_spurious_ack();
    int lat;
    exp_t x;
    spur_ack = 1'b1;
    run_job(32'd4, 32'd13, 32'd497, '{1'b0, 32'd445}, lat);
    x = sbq.pop_front();
    spur_ack = 1'b0;
    checks++; if (res_data !== x.data || res_err !== x.err || lat !== 13) begin errors++; $display("FAIL spurious_ack: got %0d err=%b lat=%0d want %0d err=%b lat=13", res_data, res_err, lat, x.data, x.err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job();
    int n = 0, bad = 0, lat;
    exp_t x;
    done_at = 1000;
    {job_msg, job_exp, job_mod} = {32'd9, 32'd5, 32'd221};
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    while (!(wb.stb_o && wb.adr_o == 32'h0000_4010) && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rstmid_reach_stat: got no STAT read within 100 cycles want one"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (wb.cyc_o !== 1'b0 || wb.stb_o !== 1'b0) begin errors++; $display("FAIL rstmid_async_drop: got %b%b want 00", wb.cyc_o, wb.stb_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    done_at = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bad += int'(res_valid !== 1'b0 || wb.cyc_o !== 1'b0);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_abandon: got %0d active cycles want 0", bad); end
    run_job(32'd9, 32'd5, 32'd221, '{1'b0, modexp(32'd9, 32'd5, 32'd221)}, lat);
    x = sbq.pop_front();
    checks++; if (res_data !== x.data || res_err !== x.err || lat !== 13) begin errors++; $display("FAIL rstmid_next_job: got %0d err=%b lat=%0d want %0d err=%b lat=13", res_data, res_err, lat, x.data, x.err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t x;
    logic [31:0] m, e, d;
    for (int k = 0; k < 3; k++) begin
      d = 32'($urandom_range(3, 60000));
      m = $urandom % d;
      e = $urandom;
      run_job(m, e, d, '{1'b0, modexp(m, e, d)}, lat);
      x = sbq.pop_front();
      checks++; if (res_data !== x.data || res_err !== x.err || lat !== 13) begin errors++; $display("FAIL b2b_job%0d: got %0d err=%b lat=%0d want %0d err=%b lat=13", k, res_data, res_err, lat, x.data, x.err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_poll_limit();
    int lat, s0 = stat_total, r0 = res_total;
    exp_t x;
    done_at = 100000;
    run_job(32'd2, 32'd3, 32'd11, '{1'b1, 32'd0}, lat);
    x = sbq.pop_front();
    done_at = 1;
    checks++; if (res_err !== x.err || res_data !== x.data) begin errors++; $display("FAIL polllim_result: got %0d err=%b want %0d err=%b", res_data, res_err, x.data, x.err); end
    checks++; if (stat_total - s0 !== 4096 || res_total - r0 !== 0) begin errors++; $display("FAIL polllim_reads: got stat=%0d res=%0d want 4096 0", stat_total - s0, res_total - r0); end
    checks++; if (lat !== 8201) begin errors++; $display("FAIL polllim_latency: got %0d want 8201", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_poll();
    test_ack_timeout();
    test_backpressure();
    test_spurious_ack();
    test_reset_mid_job();
    test_back_to_back();
    test_poll_limit();
    checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
